// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding, field width/limits and adjust-select codes for stopwatch_timer
package stopwatch_pkg;
  typedef enum logic [1:0] {PAUSED, RUN, EXPIRED} state_t;
  localparam int FIELD_W = 8;
  localparam int SEC_MAX = 59;
  localparam logic [1:0] SEL_SS = 2'd0;
  localparam logic [1:0] SEL_MM = 2'd1;
  localparam logic [1:0] SEL_HH = 2'd2;
endpackage

// File: rtl/stopwatch_timer_bcd_field.sv
// bcd_field: two-digit BCD mod-(MAX+1) register; ports clk, rst, clr, inc, dec, adj_inc -> q, carry_out (q==MAX), borrow_out (q==0)
module bcd_field import stopwatch_pkg::*; #(
  parameter int MAX = 59
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  input  logic               dec,
  input  logic               adj_inc,
  output logic [FIELD_W-1:0] q,
  output logic               carry_out,
  output logic               borrow_out
);
  localparam logic [3:0] MAX_T = 4'(MAX / 10);
  localparam logic [3:0] MAX_O = 4'(MAX % 10);
  logic [FIELD_W-1:0] q_inc, q_dec;
  assign carry_out  = q == {MAX_T, MAX_O};
  assign borrow_out = q == '0;
  always_comb begin
    q_inc = carry_out ? '0 : q[3:0] == 4'd9 ? {q[7:4] + 4'd1, 4'd0} : {q[7:4], q[3:0] + 4'd1};
    q_dec = borrow_out ? {MAX_T, MAX_O} : q[3:0] == 4'd0 ? {q[7:4] - 4'd1, 4'd9} : {q[7:4], q[3:0] - 4'd1};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (clr) q <= '0;
    else if (inc || adj_inc) q <= q_inc;
    else if (dec) q <= q_dec;
endmodule

// File: rtl/stopwatch_timer.sv
// stopwatch_timer: BCD up/down stopwatch with run/pause/expire FSM and per-field adjust; ports clk, rst, tick_cnt, tick_adj, pause, clr, mode, adj, sel -> bcd, running, expired, wrap
module stopwatch_timer import stopwatch_pkg::*; #(
  parameter int NUM_FIELDS = 2,
  parameter int TOP_MAX    = 59
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick_cnt,
  input  logic                          tick_adj,
  input  logic                          pause,
  input  logic                          clr,
  input  logic                          mode,
  input  logic                          adj,
  input  logic [1:0]                    sel,
  output logic [FIELD_W*NUM_FIELDS-1:0] bcd,
  output logic                          running,
  output logic                          expired,
  output logic                          wrap
);
  state_t state, state_nxt;
  logic pause_q, pedge, all_zero, cnt, up, dn, adj_en;
  logic [NUM_FIELDS-1:0] at_max, at_zero;
  logic [NUM_FIELDS:0] c;
  logic [NUM_FIELDS-1:0] b;
  assign pedge    = pause & ~pause_q;
  assign all_zero = &at_zero;
  assign cnt      = state == RUN && !adj && tick_cnt && !pedge && !clr;
  assign up       = cnt && !mode;
  assign dn       = cnt && mode && !all_zero;
  assign adj_en   = adj && tick_adj && state != EXPIRED && !pedge && !clr;
  assign c[0]     = up;
  assign b[0]     = dn;
  assign running  = state == RUN;
  assign expired  = state == EXPIRED;
  always_comb begin
    state_nxt = clr ? PAUSED : pedge ? (state == PAUSED ? RUN : PAUSED) : cnt && mode && all_zero ? EXPIRED : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= PAUSED;
      pause_q <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state   <= state_nxt;
      pause_q <= pause;
      wrap    <= c[NUM_FIELDS];
    end
  for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_field
    assign c[i+1] = c[i] & at_max[i];
    if (i + 1 < NUM_FIELDS) begin : g_borrow
      assign b[i+1] = b[i] & at_zero[i];
    end
    bcd_field #(.MAX(i == NUM_FIELDS - 1 ? TOP_MAX : SEC_MAX)) u_field (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .inc       (c[i]),
      .dec       (b[i]),
      .adj_inc   (adj_en && sel == 2'(i)),
      .q         (bcd[i*FIELD_W +: FIELD_W]),
      .carry_out (at_max[i]),
      .borrow_out(at_zero[i])
    );
  end
endmodule

// File: tb/tb_stopwatch_timer.sv
// tb_stopwatch_timer: directed self-checking bench for mm:ss (59) and hh:mm:ss (23) stopwatch_timer instances
module tb_stopwatch_timer;
  logic clk = 0, rst = 1, tick_cnt = 0, tick_adj = 0, pause = 0, clr = 0, mode = 0, adj = 0;
  logic [1:0] sel = 0;
  logic [15:0] bcd2;
  logic [23:0] bcd3;
  logic run2, exp2, wrap2, run3, exp3, wrap3;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  stopwatch_timer #(.NUM_FIELDS(2), .TOP_MAX(59)) dut2 (
    .clk(clk), .rst(rst), .tick_cnt(tick_cnt), .tick_adj(tick_adj), .pause(pause), .clr(clr),
    .mode(mode), .adj(adj), .sel(sel), .bcd(bcd2), .running(run2), .expired(exp2), .wrap(wrap2));
  stopwatch_timer #(.NUM_FIELDS(3), .TOP_MAX(23)) dut3 (
    .clk(clk), .rst(rst), .tick_cnt(tick_cnt), .tick_adj(tick_adj), .pause(pause), .clr(clr),
    .mode(mode), .adj(adj), .sel(sel), .bcd(bcd3), .running(run3), .expired(exp3), .wrap(wrap3));
  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic ticks(input int n);
    repeat (n) begin
      tick_cnt = 1;
      cyc(1);
      tick_cnt = 0;
    end
  endtask
  task automatic adjs(input logic [1:0] s, input int n);
    adj = 1;
    sel = s;
    repeat (n) begin
      tick_adj = 1;
      cyc(1);
      tick_adj = 0;
    end
    adj = 0;
  endtask
  task automatic press;
    pause = 1;
    cyc(1);
    pause = 0;
    cyc(1);
  endtask
  task automatic clear;
    clr = 1;
    cyc(1);
    clr = 0;
  endtask
  initial begin
    #2;
    chk("reset_bcd2", 24'(bcd2), 24'h0);
    chk("reset_flags", {21'd0, run2, exp2, wrap2}, 24'h0);
    chk("reset_bcd3", bcd3, 24'h0);
    cyc(2);
    rst = 0;
    press;
    chk("run_after_press", 24'(run2), 24'h1);
    ticks(61);
    chk("up61_bcd2", 24'(bcd2), 24'h0101);
    chk("up61_bcd3", bcd3, 24'h000101);
    chk("up61_running", 24'(run2), 24'h1);
    press;
    chk("paused", 24'(run2), 24'h0);
    adjs(2'd1, 57);
    chk("adj_mm58", 24'(bcd2), 24'h5801);
    adjs(2'd1, 3);
    chk("adj_mm_wrap2", 24'(bcd2), 24'h0101);
    chk("adj_mm_wrap3", bcd3, 24'h000101);
    adjs(2'd2, 1);
    chk("adj_sel2_ignored2", 24'(bcd2), 24'h0101);
    chk("adj_hh3", bcd3, 24'h010101);
    adjs(2'd3, 2);
    chk("adj_sel3_ignored", bcd3, 24'h010101);
    chk("adj_state_kept", 24'(run2), 24'h0);
    clear;
    chk("clr_bcd", {8'(bcd2), 16'(bcd3)}, 24'h0);
    adjs(2'd0, 2);
    mode = 1;
    press;
    ticks(1);
    chk("down_01", 24'(bcd2), 24'h0001);
    ticks(1);
    chk("down_00", 24'(bcd2), 24'h0000);
    chk("down_00_flags", {22'd0, run2, exp2}, 24'h2);
    ticks(1);
    chk("expire_flags2", {22'd0, run2, exp2}, 24'h1);
    chk("expire_flags3", {22'd0, run3, exp3}, 24'h1);
    chk("expire_bcd", 24'(bcd2), 24'h0);
    ticks(2);
    adjs(2'd0, 1);
    chk("expired_ignores", {7'd0, exp2, bcd2}, 24'h010000);
    press;
    chk("expired_to_paused", {22'd0, run2, exp2}, 24'h0);
    adjs(2'd1, 1);
    press;
    ticks(1);
    chk("borrow2", 24'(bcd2), 24'h0059);
    chk("borrow3", bcd3, 24'h000059);
    mode = 0;
    ticks(1);
    chk("mode_change_up", 24'(bcd2), 24'h0100);
    press;
    clear;
    adjs(2'd0, 59);
    adjs(2'd1, 59);
    adjs(2'd2, 23);
    chk("load_max3", bcd3, 24'h235959);
    chk("load_max2", 24'(bcd2), 24'h5959);
    press;
    ticks(1);
    chk("wrap_bcd3", bcd3, 24'h0);
    chk("wrap_pulse", {22'd0, wrap2, wrap3}, 24'h3);
    cyc(1);
    chk("wrap_one_cycle", {22'd0, wrap2, wrap3}, 24'h0);
    ticks(1);
    chk("continue_after_wrap", bcd3, 24'h000001);
    ticks(9);
    chk("at_0010", 24'(bcd2), 24'h0010);
    pause = 1;
    tick_cnt = 1;
    cyc(1);
    tick_cnt = 0;
    chk("pause_drops_tick", {7'd0, run2, bcd2}, 24'h000010);
    cyc(4);
    chk("held_pause_once", 24'(run2), 24'h0);
    pause = 0;
    cyc(1);
    clear;
    adjs(2'd1, 12);
    adjs(2'd0, 34);
    press;
    chk("load_1234", {7'd0, run2, bcd2}, 24'h011234);
    #3 rst = 1;
    #1;
    chk("async_rst_bcd", 24'(bcd2), 24'h0);
    chk("async_rst_state", {22'd0, run2, exp2}, 24'h0);
    cyc(1);
    rst = 0;
    mode = 1;
    press;
    ticks(1);
    chk("expire_again", 24'(exp2), 24'h1);
    clear;
    cyc(1);
    chk("clr_expired", {6'd0, run2, exp2, bcd2}, 24'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stopwatch_timer.md
Name: stopwatch_timer

Overview:
Parametrised BCD stopwatch/countdown timer with a run/pause/expire state machine, per-field adjust, and an up/down mode. It generalises the lab's mm:ss counter to a configurable number of fields (ss, mm, hh) and a configurable top-field limit. It adds countdown with an expiry flag and an up-count wrap pulse. It sits between the clock-divider tick generators and the seven-segment display driver.

Parameters:
NUM_FIELDS, 2, number of two-digit BCD fields (2 = mm:ss, 3 = hh:mm:ss); legal 2..3
TOP_MAX, 59, modulus-1 of the most significant field; legal 1..99; lower fields are always mod 60

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
tick_cnt  in  1  one-cycle count enable (1 Hz strobe)
tick_adj  in  1  one-cycle adjust enable (2 Hz strobe)
pause  in  1  debounced pause button level; toggles on rising edge
clr  in  1  synchronous clear
mode  in  1  0 = count up, 1 = count down
adj  in  1  adjust mode enable
sel  in  2  adjust field select: 0 = ss, 1 = mm, 2 = hh (ignored if NUM_FIELDS = 2)
bcd  out  8*NUM_FIELDS  packed fields, LSB field = seconds; per field [7:4] = tens, [3:0] = ones
running  out  1  1 while in the RUN state
expired  out  1  1 while in the EXPIRED state
wrap  out  1  one-cycle pulse when an up-count rolls from max to all-zero

Behaviour:
- Reset (async): bcd = 0, state = PAUSED, running = 0, expired = 0, wrap = 0, pause edge register = 0.
- States: PAUSED, RUN, EXPIRED. Transitions:
  - PAUSED → RUN on a pause rising edge.
  - RUN → PAUSED on a pause rising edge.
  - RUN → EXPIRED when mode = 1 and tick_cnt arrives with bcd == 0.
  - EXPIRED → PAUSED on a pause rising edge or clr.
- Pause edge: registered compare of pause against its previous value. The toggle takes effect at the clock after the rising edge is sampled. A held-high pause toggles once only.
- Priority per cycle: rst > clr > pause edge > adj > tick_cnt.
  - clr: bcd = 0, state = PAUSED.
  - pause edge in the same cycle as a tick: the state toggles and the tick is dropped.
- Counting happens only in RUN with adj = 0, one step per tick_cnt.
  - Up: the seconds field increments and carries into higher fields.
  - Down: the seconds field decrements and borrows from higher fields.
  - Latency: bcd updates on the clock edge that samples tick_cnt.
- Field arithmetic (each field is two BCD digits):
  - Lower fields: 59 → 00 with carry; 00 → 59 with borrow.
  - Top field: TOP_MAX → 00; 00 → TOP_MAX.
  - Ones digit wraps 9 → 0 with carry into the tens digit. Non-BCD codes never appear.
- Up-count overflow: all fields at max (e.g. 59:59 for NUM_FIELDS = 2, TOP_MAX = 59) plus a tick gives all-zero, wrap = 1 for one cycle, and counting continues.
- Down-count at zero: a tick moves the state to EXPIRED. bcd holds 0 with no underflow. expired stays high until the state is left.
- Adjust: when adj = 1 and state ≠ EXPIRED, counting is suspended.
  - Each tick_adj increments the field selected by sel, wrapping at its own modulus with no carry into the next field.
  - sel values outside the implemented fields: no change.
  - Adjust is allowed in both RUN and PAUSED. The state is unchanged.
- mode may change at any time; the next tick uses the new direction.
- EXPIRED ignores tick_cnt and tick_adj.
- Reset mid-operation: immediate return to the reset values regardless of state.

Decomposition:
- Package stopwatch_pkg:
  - state enum (PAUSED, RUN, EXPIRED)
  - FIELD_W = 8 and SEC_MAX = 59 constants
  - the SEL_SS / SEL_MM / SEL_HH encodings
- Sub-module bcd_field (parameter MAX):
  - two-digit BCD register with inc, dec and adj-inc controls, plus carry_out and borrow_out flags for the at-max and at-zero conditions
  - the top level instantiates NUM_FIELDS of these through a generate loop and chains carry/borrow

Test Plan:
- Reset, pause pulse, then 61 ticks (up mode, NUM_FIELDS = 2) → bcd = 16'h0101, running = 1.
- Adjust: pause, adj = 1, sel = 1, 3 × tick_adj from mm = 58 → mm = 01, ss unchanged, no carry into the next field.
- Down count: load 00:02 via adjust, mode = 1, run, 3 ticks → 00:01, 00:00, then expired = 1 with bcd = 0; a further pause edge gives PAUSED with expired = 0.
- Wrap: NUM_FIELDS = 3, TOP_MAX = 23, set to 23:59:59, one tick → bcd = 0, wrap high exactly one cycle.
- Pause edge coincident with tick_cnt in RUN at 00:10 → PAUSED, bcd stays 00:10; pause held high for 5 cycles toggles once only.
- Async rst asserted mid-count at 12:34 between clock edges → bcd = 0 and state = PAUSED immediately; clr while EXPIRED → PAUSED, bcd = 0.
